// File: rtl/qubit_measure.sv
`default_nettype none
// ============================================================================
// Module      : qubit_measure
// Description : Single-qubit readout. Computes P0/P1 from two amplitudes with
//               one shared squarer and samples an outcome using an LFSR.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif

module qubit_measure #(
    parameter int          WIDTH = `FIXED_WIDTH,
    parameter int          FRAC  = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a0_real,
    input  logic signed [WIDTH-1:0] a0_imag,
    input  logic signed [WIDTH-1:0] a1_real,
    input  logic signed [WIDTH-1:0] a1_imag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    outcome,
    output logic signed [WIDTH-1:0] p0,
    output logic signed [WIDTH-1:0] p1
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SQ   = 2'd1;
    localparam logic [1:0] S_CMP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [15:0]      C_SEED = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [WIDTH-1:0] C_MAX  = {1'b0, {(WIDTH-1){1'b1}}};

    logic [1:0]              state_q, state_d;
    logic [15:0]             lfsr_q;
    logic [FRAC-1:0]         r_q;
    logic [1:0]              sq_cnt_q;
    logic signed [WIDTH-1:0] amp_q [4];
    logic [WIDTH-1:0]        acc0_q, acc1_q;
    logic                    out_valid_q, outcome_q;
    logic [WIDTH-1:0]        p0_q, p1_q;

    logic [15:0]             w_lfsr_next;
    logic signed [WIDTH-1:0] w_sq_x;
    logic signed [2*WIDTH-1:0] w_x_ext, w_prod, w_prod_sh;
    logic [WIDTH-1:0]        w_sq_sat, w_acc_sel, w_sum, w_acc_next, w_r_ext;

    assign w_lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Shared squarer: the square is non-negative, so any set bit at or above
    // WIDTH-1 after the shift means the result exceeds MAX.
    assign w_sq_x     = amp_q[sq_cnt_q];
    assign w_x_ext    = {{WIDTH{w_sq_x[WIDTH-1]}}, w_sq_x};
    assign w_prod     = w_x_ext * w_x_ext;
    assign w_prod_sh  = w_prod >>> FRAC;
    assign w_sq_sat   = (|w_prod_sh[2*WIDTH-1:WIDTH-1]) ? C_MAX : w_prod_sh[WIDTH-1:0];
    assign w_acc_sel  = sq_cnt_q[1] ? acc1_q : acc0_q;
    assign w_sum      = w_acc_sel + w_sq_sat;
    assign w_acc_next = w_sum[WIDTH-1] ? C_MAX : w_sum;
    assign w_r_ext    = {{(WIDTH-FRAC){1'b0}}, r_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)          state_d = S_SQ;
            S_SQ:   if (sq_cnt_q == 2'd3)  state_d = S_CMP;
            S_CMP:                         state_d = S_DONE;
            S_DONE: if (out_ready)         state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q      <= C_SEED;
            r_q         <= '0;
            sq_cnt_q    <= '0;
            acc0_q      <= '0;
            acc1_q      <= '0;
            out_valid_q <= 1'b0;
            outcome_q   <= 1'b0;
            p0_q        <= '0;
            p1_q        <= '0;
            for (int i = 0; i < 4; i++) begin
                amp_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        amp_q[0] <= a0_real;
                        amp_q[1] <= a0_imag;
                        amp_q[2] <= a1_real;
                        amp_q[3] <= a1_imag;
                        r_q      <= lfsr_q[FRAC-1:0];
                        lfsr_q   <= w_lfsr_next;
                        acc0_q   <= '0;
                        acc1_q   <= '0;
                        sq_cnt_q <= '0;
                    end
                end
                S_SQ: begin
                    if (sq_cnt_q[1]) begin
                        acc1_q <= w_acc_next;
                    end else begin
                        acc0_q <= w_acc_next;
                    end
                    sq_cnt_q <= sq_cnt_q + 2'd1;
                end
                S_CMP: begin
                    outcome_q   <= (w_r_ext >= acc0_q);
                    p0_q        <= acc0_q;
                    p1_q        <= acc1_q;
                    out_valid_q <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign outcome   = outcome_q;
    assign p0        = p0_q;
    assign p1        = p1_q;

endmodule

`default_nettype wire

// File: tb/tb_qubit_measure.sv
`default_nettype none
// ============================================================================
// Module      : tb_qubit_measure
// Description : Self-checking bench for qubit_measure: vector table, corner
//               sequences and randomized measurements against a model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_qubit_measure;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] a0_real = '0, a0_imag = '0, a1_real = '0, a1_imag = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic               outcome;
    logic signed [15:0] p0, p1;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] m_lfsr   = 16'hACE1;

    qubit_measure #(.WIDTH(16), .FRAC(8), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a0_real(a0_real), .a0_imag(a0_imag), .a1_real(a1_real), .a1_imag(a1_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .outcome(outcome), .p0(p0), .p1(p1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] a0r, a0i, a1r, a1i;
        int                 ep0, ep1, eout;
    } vec_t;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int sq_model(input logic signed [15:0] x);
        int v;
        int s;
        v = int'(x);
        s = (v * v) / 256;
        return (s > 32767) ? 32767 : s;
    endfunction

    function automatic int prob_model(input logic signed [15:0] re, input logic signed [15:0] im);
        int s;
        s = sq_model(re) + sq_model(im);
        return (s > 32767) ? 32767 : s;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = 16'hACE1;
    endtask

    // Called at a negedge with the unit idle; returns at a negedge, idle again.
    task automatic run_meas(input logic signed [15:0] ar0, ai0, ar1, ai1, input bit early,
                            output int gp0, output int gp1, output int go, output int lat);
        a0_real = ar0; a0_imag = ai0; a1_real = ar1; a1_imag = ai1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a0_real = 16'($urandom); a0_imag = 16'($urandom);
        a1_real = 16'($urandom); a1_imag = 16'($urandom);
        if (early) out_ready = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        gp0 = int'(p0); gp1 = int'(p1); go = int'(outcome);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic meas_check(input string tag, input logic signed [15:0] ar0, ai0, ar1, ai1,
                              input bit early, output int go);
        int ep0, ep1, eo, gp0, gp1, lat;
        ep0 = prob_model(ar0, ai0);
        ep1 = prob_model(ar1, ai1);
        eo  = (int'(m_lfsr[7:0]) >= ep0) ? 1 : 0;
        m_lfsr = lfsr_next(m_lfsr);
        check({tag, " in_ready"}, int'(in_ready), 1);
        run_meas(ar0, ai0, ar1, ai1, early, gp0, gp1, go, lat);
        check({tag, " latency"}, lat, 5);
        check({tag, " p0"}, gp0, ep0);
        check({tag, " p1"}, gp1, ep1);
        check({tag, " outcome"}, go, eo);
    endtask

    function automatic logic signed [15:0] rand_amp();
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        return 16'(int'($urandom_range(0, 600)) - 300);
    endfunction

    initial begin
        vec_t tbl [7];
        int   gp0, gp1, go, lat, ones, seen;
        logic [15:0] hold_p0, hold_p1;
        logic        hold_out;

        tbl[0] = '{16'sd181,    16'sd0,      16'sd181,    16'sd0,      127,   127,   1};
        tbl[1] = '{16'sd256,    16'sd0,      16'sd0,      16'sd0,      256,   0,     0};
        tbl[2] = '{16'sd0,      16'sd0,      16'sd0,      -16'sd256,   0,     256,   1};
        tbl[3] = '{-16'sd32768, -16'sd32768, 16'sd0,      16'sd0,      32767, 0,     0};
        tbl[4] = '{16'sd0,      16'sd0,      -16'sd32768, 16'sd32767,  0,     32767, 1};
        tbl[5] = '{16'sd200,    16'sd200,    16'sd10,     -16'sd10,    312,   0,     0};
        tbl[6] = '{-16'sd1,     16'sd1,      16'sd255,    16'sd255,    0,     508,   1};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset outcome", int'(outcome), 0);
        check("reset p0", int'(p0), 0);
        check("reset p1", int'(p1), 0);
        do_reset();

        // Vector table; first entry sees r = 225 straight after reset
        for (int i = 0; i < 7; i++) begin
            run_meas(tbl[i].a0r, tbl[i].a0i, tbl[i].a1r, tbl[i].a1i, 1'b0, gp0, gp1, go, lat);
            m_lfsr = lfsr_next(m_lfsr);
            check($sformatf("vec%0d latency", i), lat, 5);
            check($sformatf("vec%0d p0", i), gp0, tbl[i].ep0);
            check($sformatf("vec%0d p1", i), gp1, tbl[i].ep1);
            check($sformatf("vec%0d outcome", i), go, tbl[i].eout);
        end

        // Basis states never change outcome
        for (int rep = 0; rep < 20; rep++) begin
            run_meas(16'sd256, 16'sd0, 16'sd0, 16'sd0, 1'b0, gp0, gp1, go, lat);
            m_lfsr = lfsr_next(m_lfsr);
            check($sformatf("basis0 rep%0d outcome", rep), go, 0);
            run_meas(16'sd0, 16'sd0, 16'sd0, -16'sd256, 1'b0, gp0, gp1, go, lat);
            m_lfsr = lfsr_next(m_lfsr);
            check($sformatf("basis1 rep%0d outcome", rep), go, 1);
        end

        // Early out_ready has no effect on latency or result
        meas_check("early ready", 16'sd181, 16'sd0, 16'sd181, 16'sd0, 1'b1, go);

        // Back-pressure in DONE with ignored in_valid pulses
        begin
            int ep0, eo, n;
            ep0 = prob_model(16'sd150, 16'sd40);
            eo  = (int'(m_lfsr[7:0]) >= ep0) ? 1 : 0;
            m_lfsr = lfsr_next(m_lfsr);
            a0_real = 16'sd150; a0_imag = 16'sd40; a1_real = 16'sd90; a1_imag = -16'sd70;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check("bp in_ready after accept", int'(in_ready), 0);
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk);
                @(negedge clk);
                n++;
            end
            check("bp latency", n, 5);
            check("bp p0", int'(p0), ep0);
            check("bp p1", int'(p1), prob_model(16'sd90, -16'sd70));
            check("bp outcome", int'(outcome), eo);
            hold_p0 = p0; hold_p1 = p1; hold_out = outcome;
            for (int c = 0; c < 10; c++) begin
                in_valid = c[0];
                a0_real = 16'($urandom); a1_real = 16'($urandom);
                @(posedge clk);
                @(negedge clk);
                check("bp out_valid held", int'(out_valid), 1);
                check("bp in_ready low", int'(in_ready), 0);
                check("bp p0 stable", int'(p0), int'($signed(hold_p0)));
                check("bp p1 stable", int'(p1), int'($signed(hold_p1)));
                check("bp outcome stable", int'(outcome), int'(hold_out));
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            check("bp out_valid cleared", int'(out_valid), 0);
            check("bp in_ready back", int'(in_ready), 1);
        end
        // Model LFSR only stays aligned if the pulses above were ignored
        meas_check("after bp", 16'sd181, 16'sd0, 16'sd181, 16'sd0, 1'b0, go);

        // Randomized measurements against the model
        for (int k = 0; k < 200; k++) begin
            meas_check($sformatf("rand%0d", k), rand_amp(), rand_amp(), rand_amp(), rand_amp(), 1'b0, go);
        end

        // Statistics on the equal superposition
        do_reset();
        ones = 0;
        for (int k = 0; k < 1000; k++) begin
            meas_check("stat", 16'sd181, 16'sd0, 16'sd181, 16'sd0, 1'b0, go);
            ones += go;
        end
        check("stat ones in 400..600", int'(ones >= 400 && ones <= 600), 1);

        // Reset during SQ aborts; next measurement reuses r = 225 (>= boundary)
        for (int b = 0; b < 2; b++) begin
            do_reset();
            a0_real = 16'sd181; a0_imag = 16'sd0; a1_real = 16'sd181; a1_imag = 16'sd0;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            #1;
            check("abort in_ready", int'(in_ready), 1);
            @(negedge clk);
            rst = 1'b0;
            m_lfsr = 16'hACE1;
            seen = 0;
            repeat (10) begin
                @(negedge clk);
                if (out_valid) seen = 1;
            end
            check("abort no out_valid", seen, 0);
            if (b == 0) begin
                meas_check("abort p0=225", 16'sd240, 16'sd0, 16'sd0, 16'sd0, 1'b0, go);
                check("abort r=225 vs p0=225", go, 1);
            end else begin
                meas_check("abort p0=226", 16'sd241, 16'sd0, 16'sd0, 16'sd0, 1'b0, go);
                check("abort r=225 vs p0=226", go, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/qubit_measure.md
# qubit_measure

Single-qubit measurement unit: the readout end of the gate datapath. It accepts the two complex amplitudes a single-qubit gate stage (e.g. the Hadamard stage) produces, and computes the fixed-point outcome probabilities P0 = |a0|² and P1 = |a1|² with one shared squarer over several cycles. It draws a pseudo-random fraction from an internal LFSR and returns the sampled classical outcome over a valid/ready handshake.

## Interface
- WIDTH, default `FIXED_WIDTH: signed fixed-point word width, in bits.
- FRAC, default 8: fractional bits; ONE = 2^FRAC.
- SEED, default 16'hACE1: LFSR reset value; SEED = 0 is replaced by 16'hACE1.

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: amplitude set valid.
- in_ready  out  1: unit can accept.
- a0_real, a0_imag, a1_real, a1_imag  in  WIDTH (signed): amplitudes of |0⟩ and |1⟩.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts result.
- outcome  out  1: measured bit.
- p0, p1  out  WIDTH (signed): computed probabilities.

## Operation
- FSM states: IDLE, SQ, CMP, DONE.
- **IDLE:** in_ready = 1.
  - On in_valid & in_ready, capture all four amplitudes.
  - Latch r = lfsr[FRAC-1:0] (unsigned, range [0, ONE)).
  - Advance the LFSR.
  - Clear p0/p1 accumulators, set sq_cnt = 0, go to SQ.
- **SQ:** 4 cycles, sq_cnt = 0..3, squaring in order a0_real, a0_imag, a1_real, a1_imag.
  - Product = (x*x) computed at 2*WIDTH bits, then >>> FRAC.
  - Saturate to MAX = 2^(WIDTH-1)-1.
  - Counts 0–1 accumulate into p0; counts 2–3 accumulate into p1.
  - Each addition saturates at MAX.
  - After sq_cnt = 3, go to CMP.
- **CMP:** 1 cycle.
  - outcome <= (r >= p0) ? 1 : 0, with r zero-extended to WIDTH.
  - If p0 ≥ ONE, the outcome is therefore always 0; if p0 = 0, always 1.
  - p1 is reported only and does not affect sampling.
  - Amplitudes are not renormalised; unnormalised input is used as-is.
  - Register p0/p1 to outputs, set out_valid, go to DONE.
- **DONE:** hold outcome, p0, p1 and out_valid stable until out_ready = 1; then clear out_valid and go to IDLE.
- **LFSR:** 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - Advances only on input acceptance, so the first measurement after reset uses SEED.
- in_valid outside IDLE is ignored (in_ready = 0); input data is not required to stay stable after acceptance.

## Timing
- Reset values (asynchronous): state = IDLE, in_ready = 1, out_valid = 0, outcome = 0, p0 = 0, p1 = 0, lfsr = SEED (or 16'hACE1 if SEED = 0), sq_cnt = 0.
- Latency: if acceptance happens at edge E0, SQ occupies edges E1..E4, CMP registers at E5, and out_valid is high from E5 onward.
- in_ready falls at E0 and returns high one cycle after the output handshake edge.
- Throughput is at most one measurement per 7 cycles with out_ready held high.
- Output handshake completes on a rising edge with out_valid & out_ready.
- out_ready asserted early (before DONE) has no effect.
- Reset mid-operation (SQ, CMP or DONE): the measurement is aborted, no result is emitted, and the LFSR reloads SEED.
- Saturation affects only overflowing products or sums; no wrap-around is ever visible on p0/p1.

## Test plan
- **Reset checks:** after rst pulse, in_ready = 1, out_valid = 0, outcome = 0, p0 = p1 = 0.
- **Equal superposition:** WIDTH = 16, FRAC = 8, SEED = 16'hACE1; a0 = (181, 0), a1 = (181, 0).
  - Required: p0 = p1 = 127; r = 225 ≥ 127 → outcome = 1.
  - out_valid rises exactly 5 edges after the accepting edge.
- **Basis states:**
  - a0 = (256, 0), a1 = 0 → p0 = 256, p1 = 0, outcome 0.
  - a0 = 0, a1 = (0, -256) → p0 = 0, p1 = 256, outcome 1.
  - Repeat each 20 times; the outcome never changes.
- **Saturation:** a0 = (-32768, -32768) → p0 = 32767, outcome 0.
- **Back-pressure:** hold out_ready = 0 for 10 cycles in DONE.
  - Required: outputs stable, in_ready = 0, in_valid pulses ignored.
  - Then release out_ready; in_ready rises on the next cycle.
- **Statistics and reset abort:**
  - 1000 measurements of the 181/181 state give an outcome-1 count in 400..600.
  - Assert rst during SQ: no out_valid is produced, and the next measurement reuses r = 225.
